// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the M-extension sequencer: funct3 op encodings,
// the multiply/divide FSM state encoding and the default datapath width.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    // funct3 encodings of the M-extension ops (funct7 = 0000001)
    typedef enum logic [2:0] {
        MULDIV_MUL    = 3'b000,
        MULDIV_MULH   = 3'b001,
        MULDIV_MULHSU = 3'b010,
        MULDIV_MULHU  = 3'b011,
        MULDIV_DIV    = 3'b100,
        MULDIV_DIVU   = 3'b101,
        MULDIV_REM    = 3'b110,
        MULDIV_REMU   = 3'b111
    } muldiv_op_e;

    // Sequencer states: accept, iterate, sign-correct, report
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_addsub.sv
// Adder/subtractor shared by every multiply/divide iteration and by the final
// sign correction. o_sum = i_a + (i_sub ? ~i_b : i_b) + i_cin, with carry-out.
module muldiv_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    logic [W:0] w_full;

    // Single W-bit add; subtraction is invert-and-carry-in by the caller
    always_comb begin
        w_full = {1'b0, i_a} + {1'b0, i_b ^ {W{i_sub}}} + {{W{1'b0}}, i_cin};
    end

    assign o_sum  = w_full[W-1:0];
    assign o_cout = w_full[W];

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M MUL/DIV/REM controller. Operand magnitudes are latched at
// accept, XLEN shift-add / restoring-divide iterations run on a 2*XLEN
// accumulator through one shared add/sub unit, then one cycle applies the sign.
// Optional feature macro: MULDIV_EARLY_OUT_EN (zero-operand multiply and
// divide-by-zero finish straight from IDLE).
module muldiv_sequencer
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    muldiv_state_e     r_state;
    muldiv_state_e     w_state_next;
    logic [CW-1:0]     r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic              r_neg;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_early;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_sa;
    logic              w_sb;
    logic              w_b_zero;
    logic              w_neg_in;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [XLEN:0]     w_add_a;
    logic [XLEN:0]     w_add_b;
    logic              w_add_sub;
    logic              w_add_cin;
    logic [XLEN:0]     w_sum;
    logic              w_add_cout;
    logic [2*XLEN-1:0] w_acc_step;
    logic              w_lo_zero;
    logic              w_sel_hi;
    logic [XLEN-1:0]   w_raw;
    logic [XLEN-1:0]   w_fix_val;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

    assign w_accept = (r_state == ST_IDLE) && start && !flush;
    assign w_b_zero = (srcB == '0);

    // Operand signedness and result sign from the incoming funct3
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (funct3)
            MULDIV_MUL, MULDIV_MULH, MULDIV_DIV, MULDIV_REM: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            MULDIV_MULHSU: w_a_signed = 1'b1;
            default: ;
        endcase
        w_sa = w_a_signed & srcA[XLEN-1];
        w_sb = w_b_signed & srcB[XLEN-1];
        w_mag_a = magnitude(srcA, w_sa);
        w_mag_b = magnitude(srcB, w_sb);
        // Divide by zero keeps the all-ones quotient positive; remainder follows the dividend
        if (!funct3[2])
            w_neg_in = w_sa ^ w_sb;
        else if (!funct3[1])
            w_neg_in = !w_b_zero && (w_sa ^ w_sb);
        else
            w_neg_in = w_sa;
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            w_a_zero;
    logic [XLEN-1:0] w_early_res;
    assign w_a_zero    = (srcA == '0);
    assign w_early     = funct3[2] ? w_b_zero : (w_a_zero | w_b_zero);
    assign w_early_res = funct3[2] ? (funct3[1] ? srcA : '1) : '0;
`else
    assign w_early = 1'b0;
`endif

    muldiv_addsub #(.W(XLEN + 1)) u_addsub (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_sub  (w_add_sub),
        .i_cin  (w_add_cin),
        .o_sum  (w_sum),
        .o_cout (w_add_cout)
    );

    assign w_lo_zero = (r_acc[XLEN-1:0] == '0);
    // High word holds MULH* products and remainders; low word MUL and quotients
    assign w_sel_hi  = r_op[2] ? r_op[1] : (r_op != MULDIV_MUL);
    assign w_raw     = w_sel_hi ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];

    // Adder operand muxing: iteration step in CALC, negation in FIX
    always_comb begin
        w_add_a   = '0;
        w_add_b   = '0;
        w_add_sub = 1'b0;
        w_add_cin = 1'b0;
        case (r_state)
            ST_CALC: begin
                if (r_op[2]) begin
                    // Trial subtract on the left-shifted partial remainder (bit XLEN is the shifted-out bit)
                    w_add_a   = r_acc[2*XLEN-1:XLEN-1];
                    w_add_b   = {1'b0, r_opnd};
                    w_add_sub = 1'b1;
                    w_add_cin = 1'b1;
                end else begin
                    w_add_a = {1'b0, r_acc[2*XLEN-1:XLEN]};
                    w_add_b = r_acc[0] ? {1'b0, r_opnd} : '0;
                end
            end
            ST_FIX: begin
                if (!r_op[2] && r_op != MULDIV_MUL) begin
                    // High word of a negated 2*XLEN product: ~hi + carry out of ~lo + 1
                    w_add_a   = {1'b0, ~r_acc[2*XLEN-1:XLEN]};
                    w_add_cin = w_lo_zero;
                end else begin
                    w_add_b   = {1'b0, w_raw};
                    w_add_sub = 1'b1;
                    w_add_cin = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Next accumulator value for one multiply or divide iteration
    always_comb begin
        if (r_op[2])
            w_acc_step = w_add_cout ? {w_sum[XLEN-1:0], r_acc[XLEN-2:0], 1'b1}
                                    : {r_acc[2*XLEN-2:0], 1'b0};
        else
            w_acc_step = {w_sum, r_acc[XLEN-1:1]};
        w_fix_val = r_neg ? w_sum[XLEN-1:0] : w_raw;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // FSM next state and handshake outputs; flush overrides everything
    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    stall        = 1'b1;
                    w_state_next = w_early ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                stall = 1'b1;
                if (r_cnt == '0)
                    w_state_next = ST_FIX;
            end
            ST_FIX: begin
                stall        = 1'b1;
                w_state_next = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (flush) begin
            w_state_next = ST_IDLE;
            stall        = 1'b0;
            done         = 1'b0;
        end
    end

    // Work registers: load at accept, iterate in CALC, commit result in FIX
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_neg    <= 1'b0;
            r_op     <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op  <= funct3;
                        r_neg <= w_neg_in;
                        r_cnt <= CW'(XLEN - 1);
                        if (funct3[2]) begin
                            r_acc  <= {{XLEN{1'b0}}, w_mag_a};
                            r_opnd <= w_mag_b;
                        end else begin
                            r_acc  <= {{XLEN{1'b0}}, w_mag_b};
                            r_opnd <= w_mag_a;
                        end
`ifdef MULDIV_EARLY_OUT_EN
                        if (w_early)
                            r_result <= w_early_res;
`endif
                    end
                end
                ST_CALC: begin
                    if (!flush) begin
                        r_acc <= w_acc_step;
                        if (r_cnt != '0)
                            r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_FIX: begin
                    if (!flush)
                        r_result <= w_fix_val;
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;

endmodule
